sm_reg_scan: RTL and testbench

//  Register-scan controller for the schoolMIPS board top. Sequences the regAddr debug port
//  of sm_top over a programmable address range, either automatically (timed dwell) or by

---
 rtl/sm_reg_scan.sv | 120 ++++++++++++
 tb/tb_sm_reg_scan.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/sm_reg_scan.sv
// rtl/sm_reg_scan.sv - register-scan controller sequencing the sm_top regAddr debug port for the display path
module sm_reg_scan #(
    parameter int ADDR_W  = 5,
    parameter int DATA_W  = 32,
    parameter int DWELL_W = 26
) (
    input  logic               clkIn,
    input  logic               rst_n,
    input  logic               scan_en,
    input  logic               step,
    input  logic [ADDR_W-1:0]  addr_lo,
    input  logic [ADDR_W-1:0]  addr_hi,
    input  logic [DWELL_W-1:0] dwell_len,
    output logic [ADDR_W-1:0]  regAddr,
    input  logic [DATA_W-1:0]  regData,
    output logic [ADDR_W-1:0]  disp_addr,
    output logic [DATA_W-1:0]  disp_data,
    output logic               disp_valid,
    output logic               disp_change,
    output logic               scan_wrap
);

    typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_SAMPLE, ST_HOLD} state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic [ADDR_W-1:0]  disp_addr_q, disp_addr_d;
    logic [DATA_W-1:0]  disp_data_q, disp_data_d;
    logic               valid_q, valid_d;
    logic               change_q, change_d;
    logic               wrap_q, wrap_d;
    // [0],[1] synchroniser stages, [2] previous synchronised level for edge detect
    logic [2:0]         step_sync_q;

    logic               step_rise;
    logic               wrap_cond;
    logic [ADDR_W-1:0]  next_addr;
    logic [DWELL_W-1:0] dwell_last;

    assign step_rise  = step_sync_q[1] & ~step_sync_q[2];
    // Out-of-range addresses (bounds moved under us, or lo>hi) fall back to addr_lo
    assign wrap_cond  = (addr_q >= addr_hi) || (addr_q < addr_lo);
    assign next_addr  = wrap_cond ? addr_lo : addr_q + ADDR_W'(1);
    assign dwell_last = (dwell_len == '0) ? '0 : dwell_len - DWELL_W'(1);

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        cnt_d       = cnt_q;
        disp_addr_d = disp_addr_q;
        disp_data_d = disp_data_q;
        valid_d     = valid_q;
        change_d    = 1'b0;
        wrap_d      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                addr_d  = addr_lo;
                state_d = ST_SETUP;
            end
            ST_SETUP: begin
                valid_d = 1'b0;
                state_d = ST_SAMPLE;
            end
            ST_SAMPLE: begin
                disp_data_d = regData;
                disp_addr_d = addr_q;
                valid_d     = 1'b1;
                cnt_d       = '0;
                state_d     = ST_HOLD;
            end
            ST_HOLD: begin
                disp_data_d = regData;
                change_d    = (regData != disp_data_q);
                if (scan_en && (cnt_q < dwell_len)) begin
                    cnt_d = cnt_q + DWELL_W'(1);
                end
                if ((scan_en && (cnt_q >= dwell_last)) || step_rise) begin
                    addr_d  = next_addr;
                    wrap_d  = wrap_cond;
                    valid_d = 1'b0;
                    state_d = ST_SETUP;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clkIn or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            cnt_q       <= '0;
            disp_addr_q <= '0;
            disp_data_q <= '0;
            valid_q     <= 1'b0;
            change_q    <= 1'b0;
            wrap_q      <= 1'b0;
            step_sync_q <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            cnt_q       <= cnt_d;
            disp_addr_q <= disp_addr_d;
            disp_data_q <= disp_data_d;
            valid_q     <= valid_d;
            change_q    <= change_d;
            wrap_q      <= wrap_d;
            step_sync_q <= {step_sync_q[1:0], step};
        end
    end

    assign regAddr     = addr_q;
    assign disp_addr   = disp_addr_q;
    assign disp_data   = disp_data_q;
    assign disp_valid  = valid_q;
    assign disp_change = change_q;
    assign scan_wrap   = wrap_q;

endmodule

// File: tb/tb_sm_reg_scan.sv
// tb/tb_sm_reg_scan.sv - directed self-checking bench for sm_reg_scan
module tb_sm_reg_scan;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        scan_en;
    logic        step;
    logic [4:0]  addr_lo;
    logic [4:0]  addr_hi;
    logic [25:0] dwell_len;
    logic [4:0]  regAddr;
    logic [31:0] regData;
    logic [4:0]  disp_addr;
    logic [31:0] disp_data;
    logic        disp_valid;
    logic        disp_change;
    logic        scan_wrap;

    logic [31:0] mem [32];
    int          n_vec  = 0;
    int          n_miss = 0;

    always #5 clk = ~clk;

    assign regData = mem[regAddr];

    sm_reg_scan #(.ADDR_W(5), .DATA_W(32), .DWELL_W(26)) dut (
        .clkIn       (clk),
        .rst_n       (rst_n),
        .scan_en     (scan_en),
        .step        (step),
        .addr_lo     (addr_lo),
        .addr_hi     (addr_hi),
        .dwell_len   (dwell_len),
        .regAddr     (regAddr),
        .regData     (regData),
        .disp_addr   (disp_addr),
        .disp_data   (disp_data),
        .disp_valid  (disp_valid),
        .disp_change (disp_change),
        .scan_wrap   (scan_wrap)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_addr"},   32'(regAddr), 32'h0);
        check({tag, "_daddr"},  32'(disp_addr), 32'h0);
        check({tag, "_ddata"},  disp_data, 32'h0);
        check({tag, "_valid"},  32'(disp_valid), 32'h0);
        check({tag, "_change"}, 32'(disp_change), 32'h0);
        check({tag, "_wrap"},   32'(scan_wrap), 32'h0);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = i * 32'h1111_1111;
        rst_n = 1'b0; scan_en = 1'b1; step = 1'b0;
        addr_lo = 5'd0; addr_hi = 5'd3; dwell_len = 26'd4;
        tick(2);
        check_reset_outputs("rst");
        rst_n = 1'b1;

        // Auto scan 0..3 then wrap: 6 cycles per address
        for (int k = 1; k <= 25; k++) begin
            tick(1);
            if (k <= 24) begin
                check("t1_addr", 32'(regAddr), 32'((k - 1) / 6));
                check("t1_valid", 32'(disp_valid), 32'(((k - 1) % 6) >= 2));
                if (((k - 1) % 6) >= 2) begin
                    check("t1_ddata", disp_data, ((k - 1) / 6) * 32'h1111_1111);
                    check("t1_daddr", 32'(disp_addr), 32'((k - 1) / 6));
                end
            end else begin
                check("t1_addr_wrap", 32'(regAddr), 32'h0);
            end
            check("t1_wrap", 32'(scan_wrap), 32'(k == 25));
            check("t1_change", 32'(disp_change), 32'h0);
        end

        // Manual stepping
        scan_en = 1'b0;
        tick(10);
        check("t2_noauto", 32'(regAddr), 32'h0);
        check("t2_valid", 32'(disp_valid), 32'h1);
        step = 1'b1;
        tick(2);
        check("t2_sync", 32'(regAddr), 32'h0);
        tick(1);
        check("t2_adv", 32'(regAddr), 32'h1);
        check("t2_adv_valid", 32'(disp_valid), 32'h0);
        check("t2_adv_wrap", 32'(scan_wrap), 32'h0);
        tick(2);
        check("t2_daddr", 32'(disp_addr), 32'h1);
        check("t2_dvalid", 32'(disp_valid), 32'h1);
        check("t2_ddata", disp_data, 32'h1111_1111);
        step = 1'b0;
        tick(9);
        check("t2_once", 32'(regAddr), 32'h1);
        // Second synchronised edge lands in SAMPLE and must be dropped
        step = 1'b1; tick(1);
        step = 1'b0; tick(1);
        step = 1'b1;
        tick(3);
        check("t2_drop_a", 32'(regAddr), 32'h2);
        tick(2);
        step = 1'b0;
        tick(4);
        check("t2_drop_b", 32'(regAddr), 32'h2);
        check("t2_drop_daddr", 32'(disp_addr), 32'h2);

        // Live value change while holding
        check("t3_pre_data", disp_data, 32'h2222_2222);
        check("t3_pre_change", 32'(disp_change), 32'h0);
        mem[2] = 32'hDEAD_BEEF;
        tick(1);
        check("t3_data", disp_data, 32'hDEAD_BEEF);
        check("t3_change", 32'(disp_change), 32'h1);
        tick(1);
        check("t3_change_end", 32'(disp_change), 32'h0);
        check("t3_data_hold", disp_data, 32'hDEAD_BEEF);

        // Degenerate range lo>hi, resuming from the frozen count
        addr_lo = 5'd5; addr_hi = 5'd2; scan_en = 1'b1;
        tick(3);
        check("t4_wait", 32'(regAddr), 32'h2);
        tick(1);
        check("t4_addr5", 32'(regAddr), 32'h5);
        check("t4_wrap5", 32'(scan_wrap), 32'h1);
        tick(1);
        check("t4_wrap_end", 32'(scan_wrap), 32'h0);
        tick(5);
        check("t4_addr5b", 32'(regAddr), 32'h5);
        check("t4_wrap5b", 32'(scan_wrap), 32'h1);
        addr_lo = 5'd7; addr_hi = 5'd7;
        tick(6);
        check("t4_addr7", 32'(regAddr), 32'h7);
        check("t4_wrap7", 32'(scan_wrap), 32'h1);
        tick(6);
        check("t4_addr7b", 32'(regAddr), 32'h7);
        check("t4_wrap7b", 32'(scan_wrap), 32'h1);

        // Bounds shrink below current address; zero dwell
        addr_lo = 5'd10; addr_hi = 5'd31;
        tick(6);
        check("t5_addr10", 32'(regAddr), 32'd10);
        addr_lo = 5'd0; addr_hi = 5'd3; dwell_len = 26'd0;
        tick(3);
        check("t5_wrap_addr", 32'(regAddr), 32'h0);
        check("t5_wrap", 32'(scan_wrap), 32'h1);
        tick(3);
        check("t5_dw0_a", 32'(regAddr), 32'h1);
        check("t5_dw0_wrap", 32'(scan_wrap), 32'h0);
        tick(3);
        check("t5_dw0_b", 32'(regAddr), 32'h2);

        // Asynchronous reset mid-hold
        addr_lo = 5'd9; addr_hi = 5'd9;
        tick(3);
        check("t6_addr9", 32'(regAddr), 32'd9);
        dwell_len = 26'd100;
        tick(4);
        check("t6_daddr9", 32'(disp_addr), 32'd9);
        check("t6_ddata9", disp_data, 32'h9999_9999);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("t6_rst");
        addr_lo = 5'd4; addr_hi = 5'd6; dwell_len = 26'd4;
        tick(1);
        rst_n = 1'b1;
        tick(1);
        check("t6_restart", 32'(regAddr), 32'h4);
        check("t6_restart_valid", 32'(disp_valid), 32'h0);
        tick(2);
        check("t6_daddr4", 32'(disp_addr), 32'h4);
        check("t6_dvalid4", 32'(disp_valid), 32'h1);
        check("t6_ddata4", disp_data, 32'h4444_4444);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
